// File: rtl/ad_sample_capture.sv
// ad_sample_capture
//
// Capture engine sitting upstream of MAC control. MAC control asks for a
// capture with a four-phase req/ack handshake; the engine then packs AD9238
// dual-channel 12-bit samples into 16-bit words and writes exactly sample_len
// words into the sample FIFO. The converter cannot be stalled, so a word that
// meets a full or almost-full FIFO is dropped and counted instead of waiting.
//
// Ports
//   clk            system clock, all state on its rising edge
//   rst            synchronous active-high reset
//   ad_sample_req  level request from MAC control
//   ad_sample_ack  four-phase acknowledge, set on acceptance, cleared when req is low
//   sample_len     number of words to write, latched on acceptance
//   ch_mode        00 ch0, 01 ch1, 10 interleaved ch0/ch1, 11 same as 00
//   ad_valid       one-cycle sample strobe
//   ad_ch0/ad_ch1  12-bit channel samples, valid with ad_valid
//   fifo_wr_count  FIFO write-side used count
//   fifo_full      FIFO full flag
//   fifo_wr_en     registered write strobe
//   fifo_wr_data   registered write word {3'b000, ch_id, sample}
//   busy           high while capturing
//   capture_done   one-cycle pulse together with the final write
//   overrun        sticky drop flag, cleared on the next acceptance
//   drop_cnt       saturating count of dropped words in the current capture

module ad_sample_capture #(
  parameter logic [10:0] AFULL_LEVEL = 11'd2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ad_sample_req,
  output logic        ad_sample_ack,
  input  logic [31:0] sample_len,
  input  logic [1:0]  ch_mode,
  input  logic        ad_valid,
  input  logic [11:0] ad_ch0,
  input  logic [11:0] ad_ch1,
  input  logic [10:0] fifo_wr_count,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wr_data,
  output logic        busy,
  output logic        capture_done,
  output logic        overrun,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t      state, state_n;
  logic        ack_q, ack_n;
  logic [31:0] len_q, len_n;
  logic [1:0]  mode_q, mode_n;
  logic [31:0] wcnt, wcnt_n;
  logic        pend, pend_n;
  logic [11:0] ch1_q, ch1_n;
  logic        wr_en_q, wr_en_n;
  logic [15:0] wr_data_q, wr_data_n;
  logic        done_q, done_n;
  logic        overrun_q, overrun_n;
  logic [15:0] drop_q, drop_n;

  logic        cand_valid;
  logic [15:0] cand_data;
  logic [1:0]  drop_inc;
  logic        can_write;
  logic [31:0] wcnt_inc;
  logic [16:0] drop_sum;

  // All state lives in one register bank. Reset returns every output and the
  // internal word counter and pending flag to zero; a pending ch1 word is
  // simply lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack_q     <= 1'b0;
      len_q     <= '0;
      mode_q    <= '0;
      wcnt      <= '0;
      pend      <= 1'b0;
      ch1_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state     <= state_n;
      ack_q     <= ack_n;
      len_q     <= len_n;
      mode_q    <= mode_n;
      wcnt      <= wcnt_n;
      pend      <= pend_n;
      ch1_q     <= ch1_n;
      wr_en_q   <= wr_en_n;
      wr_data_q <= wr_data_n;
      done_q    <= done_n;
      overrun_q <= overrun_n;
      drop_q    <= drop_n;
    end
  end

  // Next-state and next-output logic. In CAPTURE at most one candidate word
  // exists per cycle: a pending ch1 word takes the slot, and a strobe arriving
  // at the same time is a collision that is thrown away and charged as two
  // drops. The candidate is written only when the FIFO has room this very
  // cycle; otherwise it becomes a drop and does not advance the word count.
  // When the written word reaches sample_len the capture ends and any pending
  // ch1 word is discarded without being counted as a drop.
  always_comb begin
    state_n    = state;
    ack_n      = ack_q;
    len_n      = len_q;
    mode_n     = mode_q;
    wcnt_n     = wcnt;
    pend_n     = pend;
    ch1_n      = ch1_q;
    wr_en_n    = 1'b0;
    wr_data_n  = wr_data_q;
    done_n     = 1'b0;
    overrun_n  = overrun_q;
    drop_n     = drop_q;
    cand_valid = 1'b0;
    cand_data  = '0;
    drop_inc   = 2'd0;
    can_write  = !fifo_full && (fifo_wr_count < AFULL_LEVEL);
    wcnt_inc   = wcnt + 32'd1;
    drop_sum   = '0;

    if (!ad_sample_req) begin
      ack_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (ad_sample_req && !ack_q) begin
          ack_n     = 1'b1;
          len_n     = sample_len;
          mode_n    = ch_mode;
          wcnt_n    = '0;
          pend_n    = 1'b0;
          overrun_n = 1'b0;
          drop_n    = '0;
          if (sample_len == 32'd0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = CAPTURE;
          end
        end
      end

      CAPTURE: begin
        if (pend) begin
          cand_valid = 1'b1;
          cand_data  = {3'b000, 1'b1, ch1_q};
          pend_n     = 1'b0;
          if (ad_valid) begin
            drop_inc = 2'd2;
          end
        end else if (ad_valid) begin
          cand_valid = 1'b1;
          case (mode_q)
            2'b01: cand_data = {3'b000, 1'b1, ad_ch1};
            2'b10: begin
              cand_data = {3'b000, 1'b0, ad_ch0};
              ch1_n     = ad_ch1;
              pend_n    = 1'b1;
            end
            default: cand_data = {3'b000, 1'b0, ad_ch0};
          endcase
        end

        if (cand_valid) begin
          if (can_write) begin
            wr_en_n   = 1'b1;
            wr_data_n = cand_data;
            wcnt_n    = wcnt_inc;
            if (wcnt_inc == len_q) begin
              done_n  = 1'b1;
              pend_n  = 1'b0;
              state_n = DONE;
            end
          end else begin
            drop_inc = drop_inc + 2'd1;
          end
        end

        if (drop_inc != 2'd0) begin
          overrun_n = 1'b1;
          drop_sum  = {1'b0, drop_q} + {15'd0, drop_inc};
          drop_n    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
      end

      DONE: begin
        if (!ack_q) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign ad_sample_ack = ack_q;
  assign fifo_wr_en    = wr_en_q;
  assign fifo_wr_data  = wr_data_q;
  assign busy          = (state == CAPTURE);
  assign capture_done  = done_q;
  assign overrun       = overrun_q;
  assign drop_cnt      = drop_q;

endmodule
